// File: rtl/lfsr_pkg.sv
// Shared types and default constants for the LFSR challenge generator.
package lfsr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } fsm_e;

   localparam logic [3:0]  TAPS_4  = 4'b1001;
   localparam logic [7:0]  TAPS_8  = 8'hB8;
   localparam logic [15:0] TAPS_16 = 16'hB400;
   localparam logic [31:0] TAPS_32 = 32'h8020_0003;

   localparam logic [31:0] SEED_DEFAULT = 32'h0000_0001;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register with seed load and all-zero seed rejection.
module lfsr_core
   import lfsr_pkg::*;
#(
   parameter int         N    = 32,
   parameter logic [N-1:0] TAPS = TAPS_32,
   parameter logic [N-1:0] SEED = SEED_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         step,
   output logic [N-1:0] state,
   output logic         lockup_err
);

   logic         fb;
   logic [N-1:0] next_state;

   assign fb         = ^(state & TAPS);
   assign next_state = {state[N-2:0], fb};

   // A zero seed would lock the register forever, so fall back to SEED.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= SEED;
         lockup_err <= 1'b0;
      end else begin
         lockup_err <= 1'b0;
         if (load) begin
            if (load_val == '0) begin
               state      <= SEED;
               lockup_err <= 1'b1;
            end else begin
               state <= load_val;
            end
         end else if (step) begin
            state <= next_state;
         end
      end
   end

endmodule

// File: rtl/lfsr_challenge_gen.sv
// Burst controller issuing LFSR challenges over a valid/ready handshake.
module lfsr_challenge_gen
   import lfsr_pkg::*;
#(
   parameter int           N     = 32,
   parameter logic [N-1:0] TAPS  = TAPS_32,
   parameter logic [N-1:0] SEED  = SEED_DEFAULT,
   parameter int           CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             seed_load,
   input  logic [N-1:0]     seed_in,
   input  logic             start,
   input  logic [CNT_W-1:0] num_chal,
   output logic             chal_valid,
   input  logic             chal_ready,
   output logic [N-1:0]     chal,
   output logic [CNT_W-1:0] chal_idx,
   output logic             busy,
   output logic             done,
   output logic             lockup_err
);

   fsm_e             fsm;
   logic [CNT_W-1:0] num_q;
   logic             load;
   logic             step;
   logic             last;

   assign load = (fsm == IDLE) && seed_load;
   assign step = (fsm == RUN) && chal_valid && chal_ready;
   assign last = (chal_idx == num_q - CNT_W'(1));

   lfsr_core #(
      .N    (N),
      .TAPS (TAPS),
      .SEED (SEED)
   ) u_core (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_val   (seed_in),
      .step       (step),
      .state      (chal),
      .lockup_err (lockup_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm        <= IDLE;
         num_q      <= '0;
         chal_idx   <= '0;
         chal_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (fsm)
            IDLE: begin
               // seed_load has priority; start is dropped that cycle.
               if (!seed_load && start) begin
                  if (num_chal != '0) begin
                     num_q      <= num_chal;
                     chal_idx   <= '0;
                     chal_valid <= 1'b1;
                     busy       <= 1'b1;
                     fsm        <= RUN;
                  end else begin
                     fsm <= FIN;
                  end
               end
            end
            RUN: begin
               if (step) begin
                  chal_idx <= chal_idx + CNT_W'(1);
                  if (last) begin
                     chal_valid <= 1'b0;
                     busy       <= 1'b0;
                     fsm        <= FIN;
                  end
               end
            end
            FIN: begin
               done <= 1'b1;
               fsm  <= IDLE;
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_challenge_gen.sv
// Directed bench for lfsr_challenge_gen at N=4, TAPS=4'b1001, SEED=4'b0001.
module tb_lfsr_challenge_gen;

   localparam int N     = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             seed_load = 1'b0;
   logic [N-1:0]     seed_in = '0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] num_chal = '0;
   logic             chal_valid;
   logic             chal_ready = 1'b0;
   logic [N-1:0]     chal;
   logic [CNT_W-1:0] chal_idx;
   logic             busy;
   logic             done;
   logic             lockup_err;

   int tests = 0;
   int fails = 0;

   lfsr_challenge_gen #(
      .N     (N),
      .TAPS  (4'b1001),
      .SEED  (4'b0001),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .seed_load  (seed_load),
      .seed_in    (seed_in),
      .start      (start),
      .num_chal   (num_chal),
      .chal_valid (chal_valid),
      .chal_ready (chal_ready),
      .chal       (chal),
      .chal_idx   (chal_idx),
      .busy       (busy),
      .done       (done),
      .lockup_err (lockup_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] nxt(input logic [3:0] s);
      return {s[2:0], s[3] ^ s[0]};
   endfunction

   logic [3:0]  exp4 [4] = '{4'h1, 4'h3, 4'h7, 4'hF};
   logic [15:0] seen;
   logic [3:0]  m;

   initial begin
      // reset
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_chal", 32'(chal), 32'h1);
      chk("rst_valid", 32'(chal_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_lock", 32'(lockup_err), 32'h0);
      chk("rst_idx", 32'(chal_idx), 32'h0);

      // burst of 4 with ready held high
      chal_ready = 1'b1;
      start = 1'b1;
      num_chal = 8'd4;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("b4_chal", 32'(chal), 32'(exp4[i]));
         chk("b4_idx", 32'(chal_idx), 32'(i));
         chk("b4_valid", 32'(chal_valid), 32'h1);
         chk("b4_busy", 32'(busy), 32'h1);
         chk("b4_done_lo", 32'(done), 32'h0);
         tick();
      end
      chk("b4_fin_valid", 32'(chal_valid), 32'h0);
      chk("b4_fin_busy", 32'(busy), 32'h0);
      chk("b4_fin_done", 32'(done), 32'h0);
      tick();
      chk("b4_done", 32'(done), 32'h1);
      chk("b4_state", 32'(chal), 32'hE);
      tick();
      chk("b4_done_once", 32'(done), 32'h0);

      // full period of 15 from SEED
      rst = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b1;
      num_chal = 8'd15;
      tick();
      start = 1'b0;
      seen = '0;
      m = 4'h1;
      for (int i = 0; i < 15; i++) begin
         chk("p15_chal", 32'(chal), 32'(m));
         chk("p15_nonzero", 32'(chal != 4'h0), 32'h1);
         chk("p15_distinct", 32'(seen[chal]), 32'h0);
         seen[chal] = 1'b1;
         m = nxt(m);
         tick();
      end
      tick();
      chk("p15_done", 32'(done), 32'h1);
      start = 1'b1;
      num_chal = 8'd1;
      tick();
      start = 1'b0;
      chk("p15_wrap", 32'(chal), 32'h1);
      tick();
      tick();
      tick();

      // backpressure mid-burst
      rst = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b1;
      num_chal = 8'd6;
      tick();
      start = 1'b0;
      tick();
      tick();
      chal_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("bp_chal", 32'(chal), 32'h7);
         chk("bp_idx", 32'(chal_idx), 32'h2);
         chk("bp_valid", 32'(chal_valid), 32'h1);
         if (i < 3) tick();
      end
      chal_ready = 1'b1;
      m = 4'h7;
      for (int i = 2; i < 6; i++) begin
         chk("bp_resume", 32'(chal), 32'(m));
         chk("bp_ridx", 32'(chal_idx), 32'(i));
         m = nxt(m);
         tick();
      end
      tick();
      chk("bp_done", 32'(done), 32'h1);
      tick();

      // zero seed rejected, nonzero seed loaded
      seed_load = 1'b1;
      seed_in = 4'h0;
      tick();
      seed_load = 1'b0;
      chk("zs_lock", 32'(lockup_err), 32'h1);
      chk("zs_chal", 32'(chal), 32'h1);
      tick();
      chk("zs_lock_once", 32'(lockup_err), 32'h0);
      start = 1'b1;
      num_chal = 8'd1;
      tick();
      start = 1'b0;
      chk("zs_first", 32'(chal), 32'h1);
      tick();
      tick();
      tick();
      seed_load = 1'b1;
      seed_in = 4'hA;
      start = 1'b1;
      num_chal = 8'd2;
      tick();
      seed_load = 1'b0;
      start = 1'b0;
      chk("sd_lock", 32'(lockup_err), 32'h0);
      chk("sd_nostart", 32'(chal_valid), 32'h0);
      chk("sd_chal", 32'(chal), 32'hA);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("sd_first", 32'(chal), 32'hA);
      tick();
      chk("sd_second", 32'(chal), 32'h5);
      tick();
      tick();
      tick();

      // zero-length burst
      m = chal;
      start = 1'b1;
      num_chal = 8'd0;
      tick();
      start = 1'b0;
      chk("z_valid1", 32'(chal_valid), 32'h0);
      chk("z_done1", 32'(done), 32'h0);
      tick();
      chk("z_valid2", 32'(chal_valid), 32'h0);
      chk("z_done2", 32'(done), 32'h1);
      chk("z_state", 32'(chal), 32'(m));
      tick();
      chk("z_done3", 32'(done), 32'h0);

      // controls ignored in RUN, then reset mid-burst
      rst = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b1;
      num_chal = 8'd6;
      tick();
      start = 1'b0;
      tick();
      seed_load = 1'b1;
      seed_in = 4'h5;
      start = 1'b1;
      num_chal = 8'd1;
      tick();
      seed_load = 1'b0;
      start = 1'b0;
      chk("run_ign_chal", 32'(chal), 32'h7);
      chk("run_ign_idx", 32'(chal_idx), 32'h2);
      chk("run_ign_busy", 32'(busy), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_valid", 32'(chal_valid), 32'h0);
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_done", 32'(done), 32'h0);
      chk("abort_state", 32'(chal), 32'h1);
      tick();
      tick();
      chk("abort_no_done", 32'(done), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
